// File: rtl/shift_operand_stage.sv
// Operand-2 decode and staging register feeding the barrel shifter.
// Fetches Rs for register-specified shifts and raises a bypass when the 5-bit offset cannot express the shift.
module shift_operand_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rm_data,
    input  logic        cpsr_c,
    output logic        rs_en,
    output logic [3:0]  rs_addr,
    input  logic [31:0] rs_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  s_type,
    output logic [4:0]  offset,
    output logic [31:0] op_m,
    output logic        carry_in,
    output logic        bypass,
    output logic [31:0] bypass_result,
    output logic        bypass_carry
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_RS_WAIT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    typedef struct packed {
        logic [1:0]  s_type;
        logic [4:0]  offset;
        logic [31:0] op_m;
        logic        carry_in;
        logic        bypass;
        logic [31:0] bypass_result;
        logic        bypass_carry;
    } operand_t;

    // Maps an operand-2 encoding onto shifter controls; amt is Rs[7:0] and only matters for register shifts.
    function automatic operand_t decode(input logic [31:0] ins, input logic [31:0] rm,
                                        input logic c, input logic [7:0] amt);
        operand_t d;
        d          = '0;
        d.carry_in = c;
        if (ins[25]) begin
            d.s_type = 2'b11;
            d.offset = {ins[11:8], 1'b0};
            d.op_m   = {24'd0, ins[7:0]};
            // A zero rotate would read as RRX in the shifter, so the immediate goes round it.
            if (ins[11:8] == 4'd0) begin
                d.bypass        = 1'b1;
                d.bypass_result = {24'd0, ins[7:0]};
                d.bypass_carry  = c;
            end else begin
                d.bypass = 1'b0;
            end
        end else if (!ins[4]) begin
            d.s_type = ins[6:5];
            d.offset = ins[11:7];
            d.op_m   = rm;
            if (ins[6:5] == 2'b00 && ins[11:7] == 5'd0) begin
                d.bypass        = 1'b1;
                d.bypass_result = rm;
                d.bypass_carry  = c;
            end else begin
                d.bypass = 1'b0;
            end
        end else begin
            d.s_type = ins[6:5];
            d.op_m   = rm;
            if (amt == 8'd0) begin
                d.bypass        = 1'b1;
                d.bypass_result = rm;
                d.bypass_carry  = c;
            end else begin
                case (ins[6:5])
                    2'b00: begin
                        if (amt < 8'd32) begin
                            d.offset = amt[4:0];
                        end else begin
                            d.bypass        = 1'b1;
                            d.bypass_result = 32'd0;
                            d.bypass_carry  = (amt == 8'd32) ? rm[0] : 1'b0;
                        end
                    end
                    2'b01: begin
                        // Offset 0 on LSR means a full 32-bit shift in the shifter.
                        if (amt <= 8'd32) begin
                            d.offset = amt[4:0];
                        end else begin
                            d.bypass        = 1'b1;
                            d.bypass_result = 32'd0;
                            d.bypass_carry  = 1'b0;
                        end
                    end
                    2'b10: begin
                        d.offset = (amt < 8'd32) ? amt[4:0] : 5'd0;
                    end
                    default: begin
                        if (amt[4:0] != 5'd0) begin
                            d.offset = amt[4:0];
                        end else begin
                            d.bypass        = 1'b1;
                            d.bypass_result = rm;
                            d.bypass_carry  = rm[31];
                        end
                    end
                endcase
            end
        end
        return d;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        out_valid_r;
    logic        valid_nxt_s;
    operand_t    out_r;
    operand_t    dec_nxt_s;
    logic [31:0] instr_r;
    logic [31:0] rm_r;
    logic        c_r;
    logic        accept_s;
    logic        needs_rs_s;
    logic        load_s;
    logic        latch_s;
    logic        unused_s;

    assign unused_s   = ^rs_data[31:8];
    assign needs_rs_s = !instr[25] && instr[4];
    assign in_ready   = !flush && ((state_r == ST_EMPTY) || ((state_r == ST_FULL) && out_ready));
    assign accept_s   = in_valid && in_ready;
    assign rs_en      = accept_s && needs_rs_s;
    assign rs_addr    = instr[11:8];

    // Next-state, output-register load and Rs-wait latch control.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = out_valid_r;
        load_s      = 1'b0;
        latch_s     = 1'b0;
        dec_nxt_s   = decode(instr, rm_data, cpsr_c, 8'd0);
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s && needs_rs_s) begin
                        state_nxt_s = ST_RS_WAIT;
                        latch_s     = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = ST_FULL;
                        valid_nxt_s = 1'b1;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_RS_WAIT: begin
                    state_nxt_s = ST_FULL;
                    valid_nxt_s = 1'b1;
                    load_s      = 1'b1;
                    dec_nxt_s   = decode(instr_r, rm_r, c_r, rs_data[7:0]);
                end
                ST_FULL: begin
                    if (out_ready && accept_s && needs_rs_s) begin
                        state_nxt_s = ST_RS_WAIT;
                        valid_nxt_s = 1'b0;
                        latch_s     = 1'b1;
                    end else if (out_ready && accept_s) begin
                        valid_nxt_s = 1'b1;
                        load_s      = 1'b1;
                    end else if (out_ready) begin
                        state_nxt_s = ST_EMPTY;
                        valid_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State, output register and pending-operand storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_r       <= '0;
            instr_r     <= 32'd0;
            rm_r        <= 32'd0;
            c_r         <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= valid_nxt_s;
            if (load_s) begin
                out_r <= dec_nxt_s;
            end
            if (latch_s) begin
                instr_r <= instr;
                rm_r    <= rm_data;
                c_r     <= cpsr_c;
            end
        end
    end

    assign out_valid     = out_valid_r;
    assign s_type        = out_r.s_type;
    assign offset        = out_r.offset;
    assign op_m          = out_r.op_m;
    assign carry_in      = out_r.carry_in;
    assign bypass        = out_r.bypass;
    assign bypass_result = out_r.bypass_result;
    assign bypass_carry  = out_r.bypass_carry;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Randomized bench for shift_operand_stage: the architectural ARM operand-2 value and carry are
// computed directly and compared against what the shifter would produce from the staged operands.
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] instr = 32'd0, rm_data = 32'd0, rs_data = 32'd0;
    logic        cpsr_c = 1'b0, rs_en;
    logic [3:0]  rs_addr;
    logic        out_valid, out_ready = 1'b0;
    logic [1:0]  s_type;
    logic [4:0]  offset;
    logic [31:0] op_m, bypass_result;
    logic        carry_in, bypass, bypass_carry;

    shift_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rm_data(rm_data), .cpsr_c(cpsr_c), .rs_en(rs_en), .rs_addr(rs_addr),
        .rs_data(rs_data), .out_valid(out_valid), .out_ready(out_ready), .s_type(s_type),
        .offset(offset), .op_m(op_m), .carry_in(carry_in), .bypass(bypass),
        .bypass_result(bypass_result), .bypass_carry(bypass_carry)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: one staged result, or one instruction waiting for Rs.
    logic        m_valid = 1'b0, m_wait = 1'b0, m_byp = 1'b0, m_c = 1'b0;
    logic [32:0] m_res = 33'd0;
    logic [31:0] w_instr = 32'd0, w_rm = 32'd0;
    logic        w_c = 1'b0;
    logic        stab_pending = 1'b0;
    logic [73:0] snap = 74'd0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // {carry, result} of a shift by n (n >= 1) using wide arithmetic.
    function automatic logic [32:0] gshift(input logic [1:0] st, input int n, input logic [31:0] v);
        logic [63:0] t;
        case (st)
            2'd0: begin t = {32'd0, v} << n; return {t[32], t[31:0]}; end
            2'd1: begin t = {v, 32'd0} >> n; return {t[31], t[63:32]}; end
            2'd2: begin t = $signed({v, 32'd0}) >>> n; return {t[31], t[63:32]}; end
            default: begin t = {v, v} >> (n % 32); return {t[31], t[31:0]}; end
        endcase
    endfunction

    // Downstream shifter behaviour for a given control set.
    function automatic logic [32:0] shifter(input logic [1:0] st, input logic [4:0] off,
                                            input logic [31:0] v, input logic cin);
        if (off != 5'd0) return gshift(st, int'(off), v);
        case (st)
            2'd0:    return {cin, v};
            2'd3:    return {v[0], cin, v[31:1]};
            default: return gshift(st, 32, v);
        endcase
    endfunction

    // Architectural operand-2 value and shifter carry-out.
    function automatic logic [32:0] arch(input logic [31:0] ins, input logic [31:0] rm,
                                         input logic c, input logic [31:0] rs);
        int n;
        logic [31:0] imm;
        logic [63:0] t;
        if (ins[25]) begin
            imm = {24'd0, ins[7:0]};
            n = 2 * int'(ins[11:8]);
            if (n == 0) return {c, imm};
            t = {imm, imm} >> n;
            return {t[31], t[31:0]};
        end else if (!ins[4]) begin
            n = int'(ins[11:7]);
            if (n != 0) return gshift(ins[6:5], n, rm);
            if (ins[6:5] == 2'd0) return {c, rm};
            if (ins[6:5] == 2'd3) return {rm[0], c, rm[31:1]};
            return gshift(ins[6:5], 32, rm);
        end else begin
            n = int'(rs[7:0]);
            if (n == 0) return {c, rm};
            if (ins[6:5] == 2'd3 && n % 32 == 0) return {rm[31], rm};
            return gshift(ins[6:5], n, rm);
        end
    endfunction

    function automatic logic exp_byp(input logic [31:0] ins, input logic [31:0] rs);
        int a;
        a = int'(rs[7:0]);
        if (ins[25]) return ins[11:8] == 4'd0;
        if (!ins[4]) return ins[6:5] == 2'd0 && ins[11:7] == 5'd0;
        return a == 0 || (ins[6:5] == 2'd0 && a >= 32) || (ins[6:5] == 2'd1 && a > 32) ||
               (ins[6:5] == 2'd3 && a % 32 == 0);
    endfunction

    task automatic check_regs();
        logic [32:0] eff;
        logic [73:0] cur;
        cur = {s_type, offset, op_m, carry_in, bypass, bypass_result, bypass_carry};
        chk("out_valid", 80'(out_valid), 80'(m_valid));
        if (m_valid) begin
            eff = bypass ? {bypass_carry, bypass_result} : shifter(s_type, offset, op_m, carry_in);
            chk("result", 80'(eff), 80'(m_res));
            chk("bypass", 80'(bypass), 80'(m_byp));
            chk("carry_in", 80'(carry_in), 80'(m_c));
            if (!m_byp) chk("byp_zero", 80'({bypass_carry, bypass_result}), 80'd0);
        end
        if (stab_pending) chk("stable", 80'(cur), 80'(snap));
        snap = cur;
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rm, input logic c,
                        input logic [31:0] rs, input logic ordy, input logic fl);
        logic e_rdy, acc, needs;
        @(negedge clk);
        check_regs();
        flush = fl; in_valid = iv; instr = ins; rm_data = rm; cpsr_c = c; rs_data = rs; out_ready = ordy;
        #1;
        e_rdy = !fl && ((!m_valid && !m_wait) || (m_valid && ordy));
        acc   = iv && e_rdy;
        needs = !ins[25] && ins[4];
        chk("in_ready", 80'(in_ready), 80'(e_rdy));
        chk("rs_en", 80'(rs_en), 80'(acc && needs));
        if (acc && needs) chk("rs_addr", 80'(rs_addr), 80'(ins[11:8]));
        stab_pending = m_valid && !ordy && !fl;
        if (fl) begin
            m_valid = 1'b0; m_wait = 1'b0;
        end else if (m_wait) begin
            m_wait = 1'b0; m_valid = 1'b1;
            m_res = arch(w_instr, w_rm, w_c, rs); m_byp = exp_byp(w_instr, rs); m_c = w_c;
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (acc && needs) begin
                m_wait = 1'b1; w_instr = ins; w_rm = rm; w_c = c;
            end else if (acc) begin
                m_valid = 1'b1;
                m_res = arch(ins, rm, c, 32'd0); m_byp = exp_byp(ins, 32'd0); m_c = c;
            end
        end
    endtask

    task automatic idle(input logic [31:0] rs);
        step(1'b0, 32'd0, 32'd0, 1'b0, rs, 1'b1, 1'b0);
    endtask

    task automatic post_byp(input string name, input logic [31:0] res, input logic cy);
        @(posedge clk); #1;
        chk(name, 80'({bypass, bypass_result, bypass_carry}), 80'({1'b1, res, cy}));
    endtask

    initial begin
        logic [31:0] ins, rs;
        // Pin the model against hand-computed values.
        chk("model_imm_rot4", 80'(arch(32'h0200_04FF, 32'd0, 1'b0, 32'd0)), 80'(33'h1_FF00_0000));
        chk("model_lsl_reg32", 80'(arch(32'h0000_0310, 32'h8000_0001, 1'b0, 32'd32)), 80'(33'h1_0000_0000));
        chk("model_lsr_reg33", 80'(arch(32'h0000_0330, 32'h8000_0001, 1'b1, 32'd33)), 80'(33'h0_0000_0000));
        chk("model_ror_reg64", 80'(arch(32'h0000_0370, 32'h8000_0001, 1'b0, 32'd64)), 80'(33'h1_8000_0001));
        chk("model_rrx", 80'(arch(32'h0000_0060, 32'h8000_0001, 1'b0, 32'd0)), 80'(33'h1_4000_0000));

        #1 rst_n = 1'b0;
        #1;
        chk("rst_outs", 80'({out_valid, rs_en, s_type, offset, op_m, carry_in, bypass, bypass_result, bypass_carry}), 80'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_in_ready", 80'(in_ready), 80'd1);

        // Immediate forms.
        step(1'b1, 32'h0200_04FF, 32'h1234_5678, 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("imm_fields", 80'({s_type, offset, op_m, bypass}), 80'({2'b11, 5'd8, 32'h0000_00FF, 1'b0}));
        step(1'b1, 32'h0200_005A, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 1'b0);
        post_byp("imm_rot0", 32'h0000_005A, 1'b1);
        // Shift by immediate.
        step(1'b1, 32'h0000_0002, 32'h8000_0001, 1'b0, 32'd0, 1'b1, 1'b0);
        post_byp("lsl_imm0", 32'h8000_0001, 1'b0);
        step(1'b1, 32'h0000_0020, 32'h8000_0001, 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lsr_imm0", 80'({s_type, offset, bypass}), 80'({2'b01, 5'd0, 1'b0}));
        // Shift by register, two-cycle latency.
        step(1'b1, 32'h0000_0310, 32'h8000_0001, 1'b0, 32'd0, 1'b1, 1'b0);
        idle(32'd32);
        post_byp("lsl_reg32", 32'd0, 1'b1);
        step(1'b1, 32'h0000_0330, 32'h8000_0001, 1'b1, 32'd0, 1'b1, 1'b0);
        idle(32'd33);
        post_byp("lsr_reg33", 32'd0, 1'b0);
        step(1'b1, 32'h0000_0350, 32'h8000_0001, 1'b1, 32'd0, 1'b1, 1'b0);
        idle(32'hFFFF_FF00);
        post_byp("asr_reg0", 32'h8000_0001, 1'b1);
        step(1'b1, 32'h0000_0370, 32'h8000_0001, 1'b0, 32'd0, 1'b1, 1'b0);
        idle(32'd64);
        post_byp("ror_reg64", 32'h8000_0001, 1'b1);

        // Backpressure then back-to-back release.
        step(1'b1, 32'h0200_0311, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 1'b1, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0180 + 32'(i * 32'h20), 32'hF000_000F, 1'b0, 32'd0, 1'b1, 1'b0);

        // Flush during Rs wait, then flush against an offered instruction in EMPTY.
        step(1'b1, 32'h0000_0510, 32'h0000_00FF, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 32'd4, 1'b1, 1'b1);
        idle(32'd0);
        step(1'b1, 32'h0200_0101, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        idle(32'd0);

        // Asynchronous reset while FULL.
        step(1'b1, 32'h0200_0201, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_full", 80'({out_valid, s_type, offset, op_m, carry_in, bypass, bypass_result, bypass_carry}), 80'd0);
        m_valid = 1'b0; m_wait = 1'b0; stab_pending = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_release_ready", 80'(in_ready), 80'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            if ($urandom_range(0, 3) == 0) ins[11:8] = 4'd0;
            rs = $urandom;
            case ($urandom_range(0, 7))
                0: rs[7:0] = 8'd0;
                1: rs[7:0] = 8'd32;
                2: rs[7:0] = 8'd33;
                3: rs[7:0] = 8'd64;
                4: rs[7:0] = 8'd31;
                5: rs[7:0] = 8'($urandom_range(1, 31));
                6: rs[7:0] = 8'd255;
                default: rs[7:0] = rs[7:0];
            endcase
            step($urandom_range(0, 3) != 0, ins, $urandom, 1'($urandom), rs,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        check_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
